// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and access size codes.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane handling: load lane extraction/extension and sub-word store merging.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0: byte_lane = mem_rd[31:24];
      2'd1: byte_lane = mem_rd[23:16];
      2'd2: byte_lane = mem_rd[15:8];
      default: byte_lane = mem_rd[7:0];
    endcase
    half_lane = offset[1] ? mem_rd[15:0] : mem_rd[31:16];
  end

  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{is_signed & half_lane[15]}}, half_lane};
      default: load_data = mem_rd;
    endcase
  end

  always_comb begin
    merged_word = old_word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: merged_word[31:24] = new_data[7:0];
          2'd1: merged_word[23:16] = new_data[7:0];
          2'd2: merged_word[15:8]  = new_data[7:0];
          default: merged_word[7:0] = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged_word[15:0] = new_data[15:0];
        else           merged_word[31:16] = new_data[15:0];
      end
      default: merged_word = new_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core's memory stage and a word-wide, big-endian data memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_e  state, next_state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] buffer_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  lsu_align u_align (
    .mem_rd      (mem_rd),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_signed   (signed_q),
    .old_word    (mem_rd),
    .new_data    (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    req_err = (req_size == 2'b11)
           || ((req_size == SZ_HALF) && req_addr[0])
           || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
           || (req_addr >= 32'(MEM_BYTES));
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                  next_state = ST_RESP;
          else if (!req_write)          next_state = ST_LOAD;
          else if (req_size == SZ_WORD) next_state = ST_WRITE;
          else                          next_state = ST_RMW_RD;
        end
      end
      ST_LOAD:   next_state = ST_RESP;
      ST_RMW_RD: next_state = ST_WRITE;
      ST_WRITE:  next_state = ST_RESP;
      ST_RESP:   if (resp_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Memory address is only driven while an access is in flight.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_we     = (state == ST_WRITE) && !reset;
    mem_wd     = (state == ST_WRITE) ? buffer_q : 32'h0;
    mem_addr   = 32'h0;
    if ((state == ST_LOAD) || (state == ST_RMW_RD) || (state == ST_WRITE))
      mem_addr = {addr_q[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= 32'h0;
      buffer_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            write_q  <= req_write;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            buffer_q <= req_wdata;
            rdata_q  <= 32'h0;
            err_q    <= req_err;
          end
        end
        ST_LOAD:   rdata_q  <= write_q ? 32'h0 : load_data;
        ST_RMW_RD: buffer_q <= merged_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array reference model and a word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] tb_mem [0:63];
  logic [7:0]  ref_bytes [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Word-wide data memory with combinational read
  assign mem_rd = tb_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wd;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(string name, logic w, logic [1:0] sz, logic sg,
                                 logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] exp_rdata, logic exp_err, int exp_lat, int exp_we);
    vec_t v;
    v.name = name; v.w = w; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_we = exp_we;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refWord(input int a);
    return {ref_bytes[a], ref_bytes[a+1], ref_bytes[a+2], ref_bytes[a+3]};
  endfunction

  // Reference model: big-endian byte array, plain arithmetic on access rules
  task automatic refAccess(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int wes);
    int n;
    int base;
    logic [31:0] v;
    n = 1 << sz;
    err = (sz == 2'b11) || (addr >= 256) || ((addr % n) != 0);
    rdata = 32'h0;
    lat = 1;
    wes = 0;
    if (!err) begin
      base = int'(addr);
      if (w) begin
        for (int i = 0; i < n; i++) ref_bytes[base+i] = 8'(wdata >> (8 * (n - 1 - i)));
        lat = (sz == 2'b10) ? 2 : 3;
        wes = 1;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[base+i]);
        if (sg && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rdata = v;
        lat = 2;
      end
    end
  endtask

  // Issue one request at a negedge in IDLE; returns response and timing observations
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output int wes);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    wes = 0;
    while (!resp_valid && lat < 10) begin
      if (mem_we) wes++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) checkOutput("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err = resp_err;
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_valid", 32'(resp_valid), 32'd1);
      checkOutput("hold_rdata", resp_rdata, rdata);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wd"}, mem_wd, 32'd0);
  endtask

  task automatic runModelled(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] e_rd, a_rd;
    logic e_err, a_err;
    int e_lat, a_lat, e_we, a_we;
    refAccess(w, sz, sg, addr, wdata, e_rd, e_err, e_lat, e_we);
    applyStimulus(w, sz, sg, addr, wdata, hold, a_rd, a_err, a_lat, a_we);
    checkOutput({tag, "_rdata"}, a_rd, e_rd);
    checkOutput({tag, "_err"}, 32'(a_err), 32'(e_err));
    checkOutput({tag, "_latency"}, 32'(a_lat), 32'(e_lat));
    checkOutput({tag, "_we_cycles"}, 32'(a_we), 32'(e_we));
  endtask

  initial begin
    logic [31:0] a_rd, m_rd, pre;
    logic a_err, m_err;
    int a_lat, a_we, m_lat, m_we;
    logic w, sg;
    logic [1:0] sz;
    logic [31:0] addr;
    int r;

    vecs[0]  = mkVec("ld_word_10",    0, 2'b10, 0, 32'h10,  32'h0,        32'h11223344, 0, 2, 0);
    vecs[1]  = mkVec("ld_sbyte_20",   0, 2'b00, 1, 32'h20,  32'h0,        32'hFFFFFF80, 0, 2, 0);
    vecs[2]  = mkVec("ld_ubyte_20",   0, 2'b00, 0, 32'h20,  32'h0,        32'h00000080, 0, 2, 0);
    vecs[3]  = mkVec("ld_shalf_22",   0, 2'b01, 1, 32'h22,  32'h0,        32'h00000000, 0, 2, 0);
    vecs[4]  = mkVec("ld_shalf_20",   0, 2'b01, 1, 32'h20,  32'h0,        32'hFFFF80FF, 0, 2, 0);
    vecs[5]  = mkVec("st_byte_11",    1, 2'b00, 0, 32'h11,  32'h000000AA, 32'h0,        0, 3, 1);
    vecs[6]  = mkVec("ld_after_byte", 0, 2'b10, 0, 32'h10,  32'h0,        32'h11AA3344, 0, 2, 0);
    vecs[7]  = mkVec("st_half_12",    1, 2'b01, 0, 32'h12,  32'h0000BEEF, 32'h0,        0, 3, 1);
    vecs[8]  = mkVec("ld_after_half", 0, 2'b10, 0, 32'h10,  32'h0,        32'h11AABEEF, 0, 2, 0);
    vecs[9]  = mkVec("err_half_11",   1, 2'b01, 0, 32'h11,  32'h00001234, 32'h0,        1, 1, 0);
    vecs[10] = mkVec("err_word_12",   0, 2'b10, 0, 32'h12,  32'h0,        32'h0,        1, 1, 0);
    vecs[11] = mkVec("err_size_11",   0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1, 1, 0);
    vecs[12] = mkVec("err_range_100", 0, 2'b10, 0, 32'h100, 32'h0,        32'h0,        1, 1, 0);
    vecs[13] = mkVec("st_word_30",    1, 2'b10, 0, 32'h30,  32'h12345678, 32'h0,        0, 2, 1);
    vecs[14] = mkVec("ld_word_30",    0, 2'b10, 0, 32'h30,  32'h0,        32'h12345678, 0, 2, 0);
    vecs[15] = mkVec("ld_uhalf_12",   0, 2'b01, 0, 32'h12,  32'h0,        32'h0000BEEF, 0, 2, 0);

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    @(negedge clk);
    checkResetOutputs("post_reset");

    // Preload the whole memory through the unit so bench memory and model agree
    for (int i = 0; i < 64; i++) begin
      pre = (i == 4) ? 32'h11223344 : (i == 8) ? 32'h80FF0000 : $urandom;
      runModelled("preload", 1'b1, 2'b10, 1'b0, 32'(i * 4), pre, 0);
    end

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      refAccess(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat, m_we);
      applyStimulus(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, 0,
                    a_rd, a_err, a_lat, a_we);
      checkOutput({vecs[i].name, "_rdata"}, a_rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_err"}, 32'(a_err), 32'(vecs[i].exp_err));
      checkOutput({vecs[i].name, "_latency"}, 32'(a_lat), 32'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_we_cycles"}, 32'(a_we), 32'(vecs[i].exp_we));
    end
    checkOutput("mem_word_10", tb_mem[4], 32'h11AABEEF);

    $display("[TB] response backpressure and back-to-back accept");
    runModelled("hold_load", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3);
    runModelled("b2b_load", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0);

    $display("[TB] reset during WRITE");
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_write_we", 32'(mem_we), 32'd1);
    checkOutput("rst_write_wd", mem_wd, 32'hDEADBEEF);
    checkOutput("rst_write_addr", mem_addr, 32'h10);
    reset = 1'b1;
    #1;
    checkOutput("rst_we_gated", 32'(mem_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkResetOutputs("rst_mid");
    checkOutput("rst_mem_unchanged", tb_mem[4], refWord(16));

    $display("[TB] randomized requests against reference model");
    for (int k = 0; k < 150; k++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 15));
      sz = (r == 15) ? 2'b11 : 2'(r % 3);
      if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(256, 300));
      else                           addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) addr = addr & ~32'h1;
        if (sz == 2'b10) addr = addr & ~32'h3;
      end
      runModelled("rand", w, sz, sg, addr, $urandom, int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 64; i++) checkOutput("final_mem", tb_mem[i], refWord(i * 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
